// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the greyscale pixel stream: monitor FSM states,
// error flag bit positions, default frame geometry and the running-statistics record.
package pixel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    CLOSE    = 2'd2
  } state_e;

  localparam int ERR_COORD   = 0;
  localparam int ERR_OUTSIDE = 1;
  localparam int ERR_COUNT   = 2;
  localparam int ERR_RESTART = 3;

  localparam int DEFAULT_IMG_WIDTH  = 640;
  localparam int DEFAULT_IMG_HEIGHT = 480;

  typedef struct packed {
    logic [31:0] count;
    logic [7:0]  luma_lo;
    logic [7:0]  luma_hi;
    logic        coord_err;
  } run_stats_t;

endpackage

// File: rtl/pixel_stream_if.sv
// Pixel stream bundle: the source drives it (master), monitors and sinks observe it (slave).
interface pixel_stream_if;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;

  modport master (output pixel_data, pixel_valid, frame_start, frame_end, pixel_x, pixel_y);
  modport slave  (input  pixel_data, pixel_valid, frame_start, frame_end, pixel_x, pixel_y);
endinterface

// File: rtl/pixel_coord_tracker.sv
// Raster position of the next expected beat and the bus coordinate it should carry.
// A same-cycle clear makes the current beat pixel (0,0).
module pixel_coord_tracker #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter bit COORD_LEAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  output logic [15:0] exp_x,
  output logic [15:0] exp_y
);

  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  logic [15:0] pos_x, pos_y;
  logic [15:0] cur_x, cur_y;
  logic [15:0] nxt_x, nxt_y;

  assign cur_x = clear ? '0 : pos_x;
  assign cur_y = clear ? '0 : pos_y;

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (advance) begin
      if (cur_x == X_LAST) begin
        nxt_x = '0;
        nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + 16'd1;
      end else begin
        nxt_x = cur_x + 16'd1;
      end
    end
  end

  always_comb begin
    exp_x = cur_x;
    exp_y = cur_y;
    if (COORD_LEAD) begin
      if (cur_x < X_LAST) begin
        exp_x = cur_x + 16'd1;
      end else if (cur_y < Y_LAST) begin
        exp_x = '0;
        exp_y = cur_y + 16'd1;
      end else begin
        exp_x = '0;
        exp_y = Y_LAST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      // NOTE: non-blocking assignments for all clocked state.
      pos_x <= nxt_x;
      pos_y <= nxt_y;
    end
  end

endmodule

// File: rtl/pixel_stream_monitor.sv
// Frame-level receiver: tracks framing, checks coordinates and geometry, accumulates
// luma statistics and publishes a latched per-frame report with sticky error flags.
module pixel_stream_monitor
  import pixel_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
  parameter bit COORD_LEAD = 1'b1,
  parameter int SUM_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_stream_if.slave        pix,
  input  logic                 clear_errors,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [31:0]          pixel_count,
  output logic [SUM_WIDTH-1:0] luma_sum,
  output logic [7:0]           luma_min,
  output logic [7:0]           luma_max,
  output logic [3:0]           err_flags,
  output logic [15:0]          frames_received,
  output logic [15:0]          frames_bad
);

  localparam logic [31:0] FRAME_PIXELS = 32'(IMG_WIDTH * IMG_HEIGHT);
  localparam run_stats_t  FRESH_STATS  = '{count: '0, luma_lo: 8'hFF, luma_hi: '0, coord_err: 1'b0};

  state_e state, state_nxt;
  logic start_new, restart, close_now, accept, outside;

  run_stats_t run, base, nxt, src;
  logic [SUM_WIDTH-1:0] run_sum, base_sum, nxt_sum, src_sum;
  logic [15:0] exp_x, exp_y;
  logic        coord_mismatch, latch_report, ok_src;
  logic [3:0]  err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IN_FRAME: state_nxt = (pix.frame_end && !pix.frame_start) ? CLOSE : IN_FRAME;
      default:  state_nxt = pix.frame_start ? IN_FRAME : IDLE;
    endcase
  end

  // CLOSE lasts a single cycle and otherwise treats the bus exactly like IDLE.
  always_comb begin
    start_new = pix.frame_start;
    restart   = 1'b0;
    close_now = 1'b0;
    accept    = pix.pixel_valid && pix.frame_start;
    outside   = (pix.pixel_valid && !pix.frame_start) || pix.frame_end;
    if (state == IN_FRAME) begin
      restart   = pix.frame_start;
      close_now = pix.frame_end && !pix.frame_start;
      accept    = pix.pixel_valid;
      outside   = 1'b0;
    end
  end

  pixel_coord_tracker #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .COORD_LEAD (COORD_LEAD)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_new),
    .advance (accept),
    .exp_x   (exp_x),
    .exp_y   (exp_y)
  );

  // Statistics after this cycle's beat; a starting frame begins from fresh values.
  always_comb begin
    base           = start_new ? FRESH_STATS : run;
    base_sum       = start_new ? '0 : run_sum;
    nxt            = base;
    nxt_sum        = base_sum;
    coord_mismatch = 1'b0;
    if (accept) begin
      nxt.count = (base.count == 32'hFFFF_FFFF) ? base.count : base.count + 32'd1;
      nxt_sum   = base_sum + SUM_WIDTH'(pix.pixel_data);
      if (pix.pixel_data < base.luma_lo) nxt.luma_lo = pix.pixel_data;
      if (pix.pixel_data > base.luma_hi) nxt.luma_hi = pix.pixel_data;
      if (base.count < FRAME_PIXELS && (pix.pixel_x != exp_x || pix.pixel_y != exp_y)) begin
        coord_mismatch = 1'b1;
        nxt.coord_err  = 1'b1;
      end
    end
  end

  // A restart reports the frame as it stood before this cycle's beat.
  assign latch_report = close_now || restart;
  assign src          = restart ? run : nxt;
  assign src_sum      = restart ? run_sum : nxt_sum;
  assign ok_src       = !restart && (nxt.count == FRAME_PIXELS) && !nxt.coord_err;

  always_comb begin
    err_set              = '0;
    err_set[ERR_COORD]   = coord_mismatch;
    err_set[ERR_OUTSIDE] = outside;
    err_set[ERR_COUNT]   = close_now && (nxt.count != FRAME_PIXELS);
    err_set[ERR_RESTART] = restart;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run     <= '0;
      run_sum <= '0;
    end else begin
      run     <= nxt;
      run_sum <= nxt_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done      <= 1'b0;
      frame_ok        <= 1'b0;
      pixel_count     <= '0;
      luma_sum        <= '0;
      luma_min        <= '0;
      luma_max        <= '0;
      frames_received <= '0;
    end else begin
      frame_done <= latch_report;
      if (latch_report) begin
        frame_ok        <= ok_src;
        pixel_count     <= src.count;
        luma_sum        <= src_sum;
        luma_min        <= src.luma_lo;
        luma_max        <= src.luma_hi;
        frames_received <= frames_received + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flags  <= '0;
      frames_bad <= '0;
    end else if (clear_errors) begin
      err_flags  <= '0;
      frames_bad <= '0;
    end else begin
      err_flags <= err_flags | err_set;
      if (latch_report && !ok_src) frames_bad <= frames_bad + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_stream_monitor.sv
// Directed and randomized frames against a queue-based frame model for pixel_stream_monitor.
module tb_pixel_stream_monitor;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int WH = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_errors;
  logic        frame_done, frame_ok;
  logic [31:0] pixel_count, luma_sum;
  logic [7:0]  luma_min, luma_max;
  logic [3:0]  err_flags;
  logic [15:0] frames_received, frames_bad;

  pixel_stream_if pix ();

  pixel_stream_monitor #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COORD_LEAD (1'b1),
    .SUM_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pix             (pix),
    .clear_errors    (clear_errors),
    .frame_done      (frame_done),
    .frame_ok        (frame_ok),
    .pixel_count     (pixel_count),
    .luma_sum        (luma_sum),
    .luma_min        (luma_min),
    .luma_max        (luma_max),
    .err_flags       (err_flags),
    .frames_received (frames_received),
    .frames_bad      (frames_bad)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame model: beats of the open frame, sticky flags and counters.
  logic [7:0] q[$];
  bit         m_coord_bad;
  int         m_bad_idx;
  logic [3:0] m_err;
  int         m_rx, m_badcnt;
  int         e_count, e_sum, e_min, e_max;
  bit         e_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix.pixel_valid  = 1'b0;
    pix.frame_start  = 1'b0;
    pix.frame_end    = 1'b0;
    pix.pixel_data   = 8'h00;
    pix.pixel_x      = 16'h0;
    pix.pixel_y      = 16'h0;
    clear_errors     = 1'b0;
  endtask

  // Bus coordinate carried with raster pixel i when coordinates lead the data.
  function automatic void bus_coord(input int i, output logic [15:0] x, output logic [15:0] y);
    int px = i % W;
    int py = i / W;
    if (px < W - 1)      begin x = 16'(px + 1); y = 16'(py);    end
    else if (py < H - 1) begin x = 16'd0;       y = 16'(py + 1); end
    else                 begin x = 16'd0;       y = 16'(H - 1); end
  endfunction

  task automatic put_beat(input logic [7:0] d);
    logic [15:0] x, y;
    bus_coord(q.size(), x, y);
    if (q.size() == m_bad_idx) begin
      x = x + 16'd2;
      if (q.size() < WH) m_coord_bad = 1'b1;
    end
    pix.pixel_valid = 1'b1;
    pix.pixel_data  = d;
    pix.pixel_x     = x;
    pix.pixel_y     = y;
    q.push_back(d);
  endtask

  task automatic start_frame(input bit with_beat);
    idle_inputs();
    q.delete();
    m_coord_bad     = 1'b0;
    pix.frame_start = 1'b1;
    if (with_beat) put_beat(8'($urandom));
    cyc();
    idle_inputs();
  endtask

  task automatic send_beats(input int n, input bit data_is_index);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_inputs();
        cyc();
      end
      put_beat(data_is_index ? 8'(q.size()) : 8'($urandom));
      cyc();
      idle_inputs();
    end
  endtask

  task automatic model_close(input bit restarted);
    e_count = q.size();
    e_sum   = 0;
    e_min   = 255;
    e_max   = 0;
    foreach (q[i]) begin
      e_sum += int'(q[i]);
      if (int'(q[i]) < e_min) e_min = int'(q[i]);
      if (int'(q[i]) > e_max) e_max = int'(q[i]);
    end
    e_ok = !restarted && (e_count == WH) && !m_coord_bad;
    if (m_coord_bad)                  m_err[0] = 1'b1;
    if (!restarted && e_count != WH)  m_err[2] = 1'b1;
    if (restarted)                    m_err[3] = 1'b1;
    m_rx++;
    if (!e_ok) m_badcnt++;
  endtask

  task automatic check_report(input string tag);
    check({tag, ".done"},  32'(frame_done), 32'd1);
    check({tag, ".ok"},    32'(frame_ok), 32'(e_ok));
    check({tag, ".count"}, pixel_count, 32'(e_count));
    check({tag, ".sum"},   luma_sum, 32'(e_sum));
    check({tag, ".min"},   32'(luma_min), 32'(e_min));
    check({tag, ".max"},   32'(luma_max), 32'(e_max));
    check({tag, ".err"},   32'(err_flags), 32'(m_err));
    check({tag, ".rx"},    32'(frames_received), 32'(m_rx[15:0]));
    check({tag, ".bad"},   32'(frames_bad), 32'(m_badcnt[15:0]));
  endtask

  task automatic end_frame(input string tag, input bit with_beat);
    idle_inputs();
    pix.frame_end = 1'b1;
    if (with_beat) put_beat(8'($urandom));
    cyc();
    idle_inputs();
    model_close(1'b0);
    check_report(tag);
    cyc();
    check({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
    check({tag, ".hold"}, pixel_count, 32'(e_count));
  endtask

  task automatic pulse_clear();
    idle_inputs();
    clear_errors = 1'b1;
    cyc();
    idle_inputs();
    m_err    = '0;
    m_badcnt = 0;
    check("clear.err", 32'(err_flags), 32'd0);
    check("clear.bad", 32'(frames_bad), 32'd0);
    check("clear.rx",  32'(frames_received), 32'(m_rx[15:0]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".done"},  32'(frame_done), 32'd0);
    check({tag, ".ok"},    32'(frame_ok), 32'd0);
    check({tag, ".count"}, pixel_count, 32'd0);
    check({tag, ".sum"},   luma_sum, 32'd0);
    check({tag, ".minmax"}, {16'd0, luma_min, luma_max}, 32'd0);
    check({tag, ".err"},   32'(err_flags), 32'd0);
    check({tag, ".rx"},    32'(frames_received), 32'd0);
    check({tag, ".bad"},   32'(frames_bad), 32'd0);
  endtask

  initial begin
    idle_inputs();
    m_err = '0; m_rx = 0; m_badcnt = 0; m_bad_idx = -1; m_coord_bad = 1'b0;

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check_all_zero("reset");
    rst = 1'b0;
    cyc();

    // Clean frame, data equals raster index
    start_frame(1'b0);
    send_beats(WH, 1'b1);
    end_frame("clean", 1'b0);

    // Beat 10 carries a wrong x coordinate
    m_bad_idx = 10;
    start_frame(1'b0);
    send_beats(WH, 1'b0);
    end_frame("coord", 1'b0);
    m_bad_idx = -1;
    pulse_clear();

    // Short frame, then a clean frame leaves the count flag sticky
    start_frame(1'b0);
    send_beats(30, 1'b0);
    end_frame("short", 1'b0);
    start_frame(1'b0);
    send_beats(WH, 1'b0);
    end_frame("after_short", 1'b0);
    pulse_clear();

    // frame_start inside a frame closes it as bad and restarts
    start_frame(1'b0);
    send_beats(12, 1'b0);
    idle_inputs();
    pix.frame_start = 1'b1;
    cyc();
    idle_inputs();
    model_close(1'b1);
    check_report("restart");
    q.delete();
    m_coord_bad = 1'b0;
    send_beats(WH, 1'b0);
    end_frame("after_restart", 1'b0);
    pulse_clear();

    // Stray beat in IDLE; frame with beat on frame_start and beat on frame_end
    idle_inputs();
    pix.pixel_valid = 1'b1;
    pix.pixel_data  = 8'h5A;
    cyc();
    idle_inputs();
    m_err[1] = 1'b1;
    check("idle_beat.err", 32'(err_flags), 32'(m_err));
    check("idle_beat.rx",  32'(frames_received), 32'(m_rx[15:0]));
    start_frame(1'b1);
    send_beats(WH - 2, 1'b0);
    end_frame("edge_beats", 1'b1);
    pulse_clear();

    // Randomized frames: length around the nominal size, occasional bad coordinate
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(WH - 2, WH + 2);
      m_bad_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
      start_frame(1'($urandom_range(0, 1)));
      send_beats(n - q.size(), 1'b0);
      end_frame($sformatf("rand%0d", f), 1'b0);
    end
    m_bad_idx = -1;

    // Reset mid-frame, then a clean frame
    start_frame(1'b0);
    send_beats(20, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    cyc();
    rst = 1'b0;
    m_err = '0; m_rx = 0; m_badcnt = 0;
    cyc();
    start_frame(1'b0);
    send_beats(WH, 1'b0);
    end_frame("post_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_stream_monitor.md
Name: pixel_stream_monitor

Overview:
- Sink-side receiver for the 8-bit greyscale pixel stream (pixel_data/pixel_valid/frame_start/frame_end/pixel_x/pixel_y) produced by the camera path or the test pattern source.
- Tracks frame framing, checks per-pixel coordinates and frame geometry, and accumulates per-frame luma statistics.
- Publishes a latched per-frame report plus sticky error flags. Used for on-board display-path verification and as a bench scoreboard.

Parameters:
IMG_WIDTH, 640, expected pixels per line.
IMG_HEIGHT, 480, expected lines per frame.
COORD_LEAD, 1, bus coordinate convention: 1 = pixel_x/pixel_y lead the data by one pixel position; 0 = coordinates match the data.
SUM_WIDTH, 32, luma accumulator width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pixel_data  in  8  pixel luma
pixel_valid  in  1  pixel beat qualifier
frame_start  in  1  one-cycle frame-begin pulse
frame_end  in  1  one-cycle frame-close pulse
pixel_x  in  16  bus x coordinate
pixel_y  in  16  bus y coordinate
clear_errors  in  1  synchronous clear of sticky err_flags and frames_bad
frame_done  out  1  one-cycle pulse: report registers updated
frame_ok  out  1  last frame had exact count and no coordinate error
pixel_count  out  32  last frame's valid-beat count
luma_sum  out  SUM_WIDTH  last frame's sum of pixel_data
luma_min  out  8  last frame's minimum
luma_max  out  8  last frame's maximum
err_flags  out  4  sticky: [0] coord mismatch, [1] beat/frame_end outside frame, [2] count mismatch, [3] frame_start inside frame
frames_received  out  16  closed-frame counter, wraps
frames_bad  out  16  closed frames with frame_ok=0, wraps

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Running accumulators are cleared.
- FSM state IDLE:
  - frame_start=1 → IN_FRAME. Clear run_count, run_sum and the coordinate tracker; set run_min=8'hFF, run_max=0, frame_coord_err=0.
  - A pixel_valid in the same cycle as frame_start is accepted as pixel index 0.
- FSM state IN_FRAME:
  - Each pixel_valid beat increments run_count (saturating at 2^32-1), adds zero-extended data to run_sum (wraps modulo 2^SUM_WIDTH), and updates run_min/run_max.
  - The coordinate check applies only while run_count < IMG_WIDTH*IMG_HEIGHT.
  - Expected bus coordinate for pixel (x,y):
    - COORD_LEAD=0: (x,y).
    - COORD_LEAD=1: (x+1,y) if x<W-1; else (0,y+1) if y<H-1; else (0,H-1).
  - A coordinate mismatch sets frame_coord_err and err_flags[0].
  - frame_end → CLOSE. A beat in the same cycle as frame_end is counted before the frame closes.
  - frame_start → set err_flags[3], close the current frame as bad (frame_done pulses, frame_ok=0), then restart the accumulators as in IDLE and stay in IN_FRAME.
- FSM state CLOSE (one cycle):
  - Latch pixel_count, luma_sum, luma_min, luma_max.
  - frame_ok = (run_count==W*H) && !frame_coord_err. If the count differs, set err_flags[2].
  - Pulse frame_done, increment frames_received, and increment frames_bad if !frame_ok. Return to IDLE.
  - frame_done is asserted exactly 1 cycle after the frame_end cycle.
- Latching empty frame: pixel_count=0, luma_min=8'hFF, luma_max=0.
- In IDLE, a pixel_valid or frame_end sets err_flags[1]. The beat is otherwise ignored.
- clear_errors has priority over a same-cycle error set. err_flags then reads 0 next cycle; frames_received is unaffected.
- The report registers hold their values until the next CLOSE.

Decomposition:
- pixel_stream_pkg holds:
  - FSM state encoding (IDLE, IN_FRAME, CLOSE);
  - err_flags bit indices (ERR_COORD=0, ERR_OUTSIDE=1, ERR_COUNT=2, ERR_RESTART=3);
  - the default IMG_WIDTH/IMG_HEIGHT constants, shared with the pattern source and the display path.
- Sub-module pixel_coord_tracker:
  - expected x/y counters with wrap, plus the COORD_LEAD mapping;
  - inputs are clear and advance; outputs are exp_x and exp_y.

Test Plan:
- W=8,H=4, COORD_LEAD=1, clean frame with data=index (0..31) → 1 cycle after frame_end: frame_done=1, frame_ok=1, pixel_count=32, luma_sum=496, min=0, max=31, err_flags=0.
- Same frame with beat 10 carrying pixel_x=5 instead of 3 → frame_ok=0, err_flags[0]=1, frames_bad=1, pixel_count=32.
- Frame with 30 beats → pixel_count=30, frame_ok=0, err_flags=4'b0100. A following clean frame → frame_ok=1, err_flags still 4'b0100 until clear_errors.
- frame_start reasserted after 12 beats, then a clean 32-beat frame → two frame_done pulses: first with pixel_count=12 and frame_ok=0 (err_flags[3]=1), second with frame_ok=1; frames_received=2.
- pixel_valid in IDLE, and frame_end plus last beat in the same cycle → err_flags[1]=1; the last beat is counted (pixel_count=32).
- rst asserted mid-frame after 20 beats, then a clean frame → all outputs 0 during reset; the next report shows pixel_count=32, frames_received=1.
